// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package wide_add_sequencer_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 16-bit ripple-carry adder shared by the wide-operand datapath.
module ripple_carry_adder
    import wide_add_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: one 16-bit adder reused over WORDS cycles,
// least-significant slice first, with the carry registered between slices.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding slice idx, one slice per cycle
//   DONE  | result held on sum/cout until out_ready
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*SLICE_W-1:0] a,
    input  logic [WORDS*SLICE_W-1:0] b,
    input  logic                     cin,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*SLICE_W-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       sum_reg;
    logic               carry;
    logic               cout_reg;
    logic [IDX_W-1:0]   idx;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] add_sum;
    logic               add_cout;

    assign a_slice = a_reg[idx*SLICE_W +: SLICE_W];
    assign b_slice = b_reg[idx*SLICE_W +: SLICE_W];

    ripple_carry_adder u_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is folded into the add: a + ~b + 1.
                        a_reg    <= a;
                        b_reg    <= op_sub ? ~b : b;
                        carry    <= op_sub | cin;
                        idx      <= '0;
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx*SLICE_W +: SLICE_W] <= add_sum;
                    carry <= add_cout;
                    if (idx == LAST_IDX) begin
                        cout_reg <= add_cout;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision add/subtract sequencer that reuses one 16-bit ripple-carry adder over `WORDS` cycles to produce a `WORDS*16`-bit result. It captures full-width operands through a valid/ready handshake and feeds one 16-bit slice per cycle into the adder, least-significant slice first, registering the carry between slices. It returns the assembled sum and final carry through a second valid/ready handshake. It sits between wide-operand producers and the shared 16-bit adder datapath, trading latency for area.

## Interface
- `WORDS`, default 4: number of 16-bit slices; must be ≥2; operand width is `WORDS*16`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in `WORDS*16`: operand A.
- `b` in `WORDS*16`: operand B.
- `cin` in 1: carry-in for an add; ignored when `op_sub=1`.
- `op_sub` in 1: 0 computes a+b+cin; 1 computes a−b (as a+~b+1).
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `sum` out `WORDS*16`: result.
- `cout` out 1: carry out of the top slice; for a subtract, 1 means no borrow.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid&in_ready`: register a, b (inverted if `op_sub`), and carry = `op_sub ? 1 : cin`; set idx=0; clear sum register; go to RUN.
- RUN, each cycle:
  - Adder inputs are `a_reg[idx*16+:16]`, `b_reg[idx*16+:16]` and the carry register.
  - At the edge: `sum[idx*16+:16]` ← adder sum; carry ← adder cout; idx ← idx+1.
  - When idx==WORDS−1 at the edge, go to DONE; `cout` ← adder cout.
- DONE:
  - `out_valid=1`; `sum` and `cout` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready=0`; `in_valid` is ignored until back in IDLE. There is no overlap of consecutive operations.
- idx is a `$clog2(WORDS)`-bit counter. It never wraps inside an operation and is reset to 0 on each accept.
- Arithmetic is modulo 2^(WORDS*16); overflow is reported only through `cout`.
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `busy=0`, `sum=0`, `cout=0`, idx=0, carry=0.
- Reset asserted mid-RUN or mid-DONE abandons the operation immediately, with no partial result visible. The first operation after reset is computed fully correctly.

## Timing
- Operand accept at edge k. RUN occupies edges k+1 … k+WORDS. `out_valid` rises after edge k+WORDS, so latency is WORDS cycles from accept to `out_valid`.
- With `out_ready` held at 1, the handshake completes at edge k+WORDS+1. The next accept is possible at edge k+WORDS+2, giving a sustained rate of one operation per WORDS+2 cycles.
- `in_ready`, `out_valid` and `busy` are decoded from registered state, with no combinational path from `in_valid`/`out_ready`.
- `in_valid` asserted while in RUN or DONE is not captured. The producer must hold it until `in_ready`.
- Critical path is one 16-bit ripple plus the slice mux and carry register; it is independent of WORDS.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DONE), slice width constant `SLICE_W=16`.
- One sub-module instance: the team's existing 16-bit `ripple_carry_adder`. Its ports are a, b, cin, sum, cout. Do not duplicate adder logic in this block.
- Operand, sum, carry and idx registers plus the FSM live in `wide_add_sequencer`.

## Test plan
All scenarios use WORDS=4.
1. Carry propagation: a=0x0000_0000_0000_FFFF, b=1, cin=0, add. Required: sum=0x0000_0000_0001_0000, cout=0, `out_valid` exactly 4 cycles after accept.
2. Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, add. Required: sum=0, cout=1. Random a, b, cin for 1000 ops against a 65-bit reference model.
3. Subtract:
   - a=5, b=7. Required: sum=0xFFFF_FFFF_FFFF_FFFE, cout=0.
   - a=7, b=5, cin=0 (cin must be ignored). Required: sum=2, cout=1.
4. Backpressure: hold `out_ready=0` for 10 cycles in DONE, pulsing `in_valid` with new operands. Required: sum/cout stable, `in_ready=0`, new operands not captured, first result delivered intact when `out_ready` rises.
5. Reset mid-operation: assert `rst` while idx=2 in RUN. Required: `out_valid=0`, sum=0, `busy=0`, `in_ready=1` immediately. The next operation, 0x1234+0x4321, returns 0x5555, cout=0.
6. Back-to-back: with `in_valid` and `out_ready` held high for 5 operations, accepts occur every 6 cycles and results emerge in order with no loss.
